inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 93 +++++++++
 tb/tb_inst_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with one outstanding read and a 2-entry queue
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic [31:0]      inst_count
);

    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        inflight;
    logic [31:0] q_inst [2];
    logic [31:0] q_pc   [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [31:0] pop_count;
    logic        pop;
    logic        push;
    logic [2:0]  occupancy;

    assign imem_addr = pc[IM_AW+1:2];

    // Handshake, request throttling and output gating; outputs read as zero while in reset
    always_comb begin
        inst_valid = !rst && (count != 2'd0);
        pop        = inst_valid && inst_ready;
        push       = inflight && !redirect_valid;
        // Slots that will be occupied once this cycle's pop and the in-flight response settle
        occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        imem_req   = !rst && !redirect_valid && (occupancy < 3'd2);
        inst       = inst_valid ? q_inst[rd_ptr] : 32'h0;
        inst_pc    = inst_valid ? q_pc[rd_ptr] : 32'h0;
        inst_count = rst ? 32'h0 : pop_count;
    end

    // Control state: fetch PC, in-flight tracking, queue pointers and delivered count
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            req_pc    <= 32'h0;
            inflight  <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            pop_count <= 32'h0;
        end else begin
            inflight <= imem_req;
            // A pop in a redirect cycle is still a real delivery to decode
            if (pop) begin
                pop_count <= pop_count + 32'd1;
            end
            if (redirect_valid) begin
                pc     <= {redirect_pc[31:2], 2'b00};
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (imem_req) begin
                    pc     <= pc + 32'd4;
                    req_pc <= pc;
                end
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // Queue storage; the response is tagged with the PC that requested it
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized checks for inst_fetch
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_count;

    int errors = 0;
    int checks = 0;

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .IM_AW    (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_count     (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word k holds k; junk when no read was issued
    always @(posedge clk) begin
        imem_rdata <= imem_req ? {24'h0, imem_addr} : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    logic [31:0] wrap_pc   [4];
    logic [31:0] wrap_inst [4];
    logic [31:0] exp_pc;
    int          npops;
    int          idle;
    int          max_idle;
    logic        r;

    initial begin
        wrap_pc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        wrap_inst = '{32'h0000_00FE, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0001};
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // Reset state
        cyc();
        cyc();
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_count", inst_count, 0);

        // Streaming with decode always ready
        cyc();
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                cyc();
                #1;
            end
            check("st_req", imem_req, 1);
            check("st_addr", imem_addr, c);
            check("st_valid", inst_valid, c >= 2);
            check("st_count", inst_count, (c > 2) ? c - 2 : 0);
            if (c >= 2) begin
                check("st_pc", inst_pc, 4 * (c - 2));
                check("st_inst", inst, c - 2);
            end
        end
        cyc();
        #1;
        check("st_count_end", inst_count, 6);

        // Reset mid-stream with a simultaneous redirect and pop
        cyc();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        inst_ready     = 1'b1;
        #1;
        check("mr_req", imem_req, 0);
        check("mr_valid", inst_valid, 0);
        check("mr_inst", inst, 0);
        check("mr_pc", inst_pc, 0);
        check("mr_count", inst_count, 0);

        // Restart at RESET_PC with decode stalled, then released
        cyc();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                cyc();
                inst_ready = (c >= 6);
                #1;
            end
            check("sl_req", imem_req, (c < 2) || (c >= 6));
            if (c < 2) check("sl_addr_a", imem_addr, c);
            if (c >= 6) check("sl_addr_b", imem_addr, c - 4);
            check("sl_valid", inst_valid, c >= 2);
            check("sl_count", inst_count, (c > 6) ? c - 6 : 0);
            if (c >= 2 && c < 6) begin
                check("sl_hold_pc", inst_pc, 0);
                check("sl_hold_inst", inst, 0);
            end
            if (c >= 6) begin
                check("sl_pc", inst_pc, 4 * (c - 6));
                check("sl_inst", inst, c - 6);
            end
        end

        // Redirect from a full queue, with a pop in the redirect cycle
        do_reset();
        inst_ready = 1'b0;
        #1;
        for (int c = 1; c < 4; c++) begin
            cyc();
            #1;
        end
        check("rq_full_valid", inst_valid, 1);
        check("rq_full_req", imem_req, 0);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        inst_ready     = 1'b1;
        #1;
        check("rq_req_r0", imem_req, 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("rq_valid_r1", inst_valid, 0);
        check("rq_req_r1", imem_req, 1);
        check("rq_addr_r1", imem_addr, 8'h10);
        check("rq_count_r1", inst_count, 1);
        cyc();
        #1;
        check("rq_valid_r2", inst_valid, 0);
        cyc();
        #1;
        check("rq_valid_r3", inst_valid, 1);
        check("rq_pc_r3", inst_pc, 32'h40);
        check("rq_inst_r3", inst, 32'h10);
        check("rq_count_r3", inst_count, 1);
        cyc();
        #1;
        check("rq_pc_r4", inst_pc, 32'h44);
        check("rq_inst_r4", inst, 32'h11);
        check("rq_count_r4", inst_count, 2);

        // Redirect near the top of memory while a read is in flight; PC wraps
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        #1;
        check("wr_req_r0", imem_req, 0);
        for (int k = 1; k < 7; k++) begin
            cyc();
            redirect_valid = 1'b0;
            #1;
            if (k < 3) begin
                check("wr_valid_gap", inst_valid, 0);
            end else begin
                check("wr_valid", inst_valid, 1);
                check("wr_pc", inst_pc, wrap_pc[k-3]);
                check("wr_inst", inst, wrap_inst[k-3]);
            end
        end

        // Random ready, redirects and resets against an in-order stream model
        do_reset();
        exp_pc   = 32'h0;
        npops    = 0;
        idle     = 0;
        max_idle = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i > 0) cyc();
            r              = ($urandom_range(999) == 0);
            rst            = r;
            inst_ready     = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(31) == 0);
            redirect_pc    = $urandom;
            #1;
            check("rnd_count", inst_count, r ? 0 : npops);
            if (r) begin
                exp_pc = 32'h0;
                npops  = 0;
                idle   = 0;
            end else begin
                if (inst_valid && inst_ready) begin
                    check("rnd_pc", inst_pc, exp_pc);
                    check("rnd_inst", inst, {24'h0, exp_pc[9:2]});
                    exp_pc = exp_pc + 32'd4;
                    npops++;
                end
                if (redirect_valid || inst_valid) begin
                    idle = 0;
                end else begin
                    idle++;
                    if (idle > max_idle) max_idle = idle;
                end
                if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        cyc();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rnd_count_end", inst_count, npops);
        check("rnd_idle_le2", max_idle <= 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
